// File: rtl/cosim_loopback_multi_pkg.sv
// Shared types for the multi-channel cosim loopback.
// Provides the per-channel transform selector enum.
package cosim_loopback_pkg;

  localparam int MODE_BITS = 2;

  typedef enum logic [MODE_BITS-1:0] {
    MODE_PASS   = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_INCR   = 2'd2,
    MODE_BSWAP  = 2'd3
  } loopback_mode_e;

endpackage

// File: rtl/cosim_loopback_multi_if.sv
// Endpoint-side token streams of the loopback, one bit/lane per channel.
// master = endpoint side, slave = loopback side.
interface cosim_loopback_multi_if #(
  parameter int N = 2,
  parameter int W = 24
);
  logic [N-1:0]        DataOutValid;
  logic [N-1:0]        DataOutReady;
  logic [N-1:0][W-1:0] DataOut;
  logic [N-1:0]        DataInValid;
  logic [N-1:0]        DataInReady;
  logic [N-1:0][W-1:0] DataIn;

  modport master (
    output DataOutValid, DataOut, DataInReady,
    input  DataOutReady, DataInValid, DataIn
  );

  modport slave (
    input  DataOutValid, DataOut, DataInReady,
    output DataOutReady, DataInValid, DataIn
  );
endinterface

// File: rtl/cosim_loopback_multi_fifo.sv
// Per-channel FIFO with valid/ready on both sides.
// Ports: clk, rst, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module cosim_loopback_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Extra pointer bit tells full from empty when indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // Ready comes only from stored state: a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_ready && !empty;

  // Idle output is zero rather than a stale entry.
  assign out_data = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= in_data;
  end
endmodule

// File: rtl/cosim_loopback_multi.sv
// Multi-channel cosim loopback: transform on accept, FIFO, return.
// Ports: clk, rst, bus (token streams), Mode, RxCount, TxCount.
module cosim_loopback_multi
  import cosim_loopback_pkg::*;
#(
  parameter int NUM_CHANNELS   = 2,
  parameter int TYPE_SIZE_BITS = 24,
  parameter int DEPTH          = 4,
  parameter int CNT_BITS       = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  cosim_loopback_multi_if.slave                  bus,
  input  logic [NUM_CHANNELS-1:0][MODE_BITS-1:0] Mode,
  output logic [NUM_CHANNELS-1:0][CNT_BITS-1:0]  RxCount,
  output logic [NUM_CHANNELS-1:0][CNT_BITS-1:0]  TxCount
);
  localparam int W  = TYPE_SIZE_BITS;
  localparam int NB = W / 8;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [W-1:0]        din;
    logic [W-1:0]        swp;
    logic [W-1:0]        xf;
    logic [W-1:0]        dout;
    logic                rdy;
    logic                vld;
    logic                push;
    logic                pop;
    logic [CNT_BITS-1:0] rx;
    logic [CNT_BITS-1:0] tx;

    assign din = bus.DataOut[i];

    always_comb begin
      swp = '0;
      for (int b = 0; b < NB; b++) begin
        swp[b*8 +: 8] = din[(NB-1-b)*8 +: 8];
      end
    end

    // Transform is fixed at enqueue time with this cycle's Mode.
    always_comb begin
      xf = din;
      unique case (loopback_mode_e'(Mode[i]))
        MODE_PASS:   xf = din;
        MODE_INVERT: xf = ~din;
        MODE_INCR:   xf = din + 1'b1;
        MODE_BSWAP:  xf = swp;
      endcase
    end

    cosim_loopback_fifo #(
      .WIDTH (W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.DataOutValid[i]),
      .in_ready  (rdy),
      .in_data   (xf),
      .out_valid (vld),
      .out_ready (bus.DataInReady[i]),
      .out_data  (dout)
    );

    assign push = bus.DataOutValid[i] && rdy;
    assign pop  = vld && bus.DataInReady[i];

    always_ff @(posedge clk) begin
      if (rst) begin
        rx <= '0;
        tx <= '0;
      end else begin
        if (push) rx <= rx + 1'b1;
        if (pop)  tx <= tx + 1'b1;
      end
    end

    assign bus.DataOutReady[i] = rdy;
    assign bus.DataInValid[i]  = vld;
    assign bus.DataIn[i]       = dout;
    assign RxCount[i]          = rx;
    assign TxCount[i]          = tx;
  end
endmodule
